// File: rtl/divider_seq_n_bits_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// State encoding and counter-width function used by the FSM datapath.
package divider_seq_n_bits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divider_seq_n_bits_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, and shift the quotient bit into Q.
module div_step_n_bits
  import divider_seq_n_bits_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] q_o
);

  logic [N:0] r_sh;
  logic [N:0] dif;
  logic       ge;

  assign r_sh = {r_i[N-1:0], q_i[N-1]};
  assign ge   = (r_sh >= {1'b0, d_i});
  assign dif  = r_sh - {1'b0, d_i};
  assign r_o  = ge ? dif : r_sh;
  assign q_o  = {q_i[N-2:0], ge};

endmodule

// File: rtl/divider_seq_n_bits.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional macro DIVIDER_DIV0_DETECT_EN adds a divide-by-zero fast path.
module divider_seq_n_bits
  import divider_seq_n_bits_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div0
);

  localparam int CW = clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [N:0]     r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N:0]     r_nx;
  logic [N-1:0]   q_nx;
`ifdef DIVIDER_DIV0_DETECT_EN
  logic           div0_q, div0_d;
`endif

  div_step_n_bits #(.N(N)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_nx),
    .q_o (q_nx)
  );

  // State and datapath registers, cleared by the async reset.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIVIDER_DIV0_DETECT_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIVIDER_DIV0_DETECT_EN
      div0_q  <= div0_d;
`endif
    end
  end

  // Next-state and datapath update; results load only on entry to DONE.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIVIDER_DIV0_DETECT_EN
    div0_d  = div0_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef DIVIDER_DIV0_DETECT_EN
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            div0_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      (state_q == RUN): begin
        q_d   = q_nx;
        r_d   = r_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quo_d   = q_nx;
          rem_d   = r_nx[N-1:0];
`ifdef DIVIDER_DIV0_DETECT_EN
          div0_d  = 1'b0;
`endif
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIVIDER_DIV0_DETECT_EN
  assign div0      = div0_q;
`else
  assign div0      = 1'b0;
`endif

endmodule
